input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end stage between the board's raw pushbuttons/slide switches and the top-level design mux.
//  Per input: 2-FF synchronizer, counter-based debounce, clean level output.
//  Also produces single-cycle press/release/change pulses.
//  Downstream logic (design select on SW[9], design KEY inputs) consumes only the conditioned signals.
// PARAMETERS
//  N_KEYS           2        number of pushbuttons (active-low on board)
//  N_SW             10       number of slide switches (active-high)
//  DEBOUNCE_CYCLES  500000   consecutive stable cycles required to accept a change (10 ms @ 50 MHz); legal >= 2
//  CNT_W            derived  localparam $clog2(DEBOUNCE_CYCLES); not overridable
// PORTS
//  clk          in   1       single system clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  key_raw      in   N_KEYS  raw pushbuttons, asynchronous, 0 = pressed
//  sw_raw       in   N_SW    raw switches, asynchronous
//  key_level    out  N_KEYS  debounced key level, same polarity as key_raw (0 = pressed)
//  key_press    out  N_KEYS  1-cycle pulse when key_level[i] goes 1->0
//  key_release  out  N_KEYS  1-cycle pulse when key_level[i] goes 0->1
//  sw_level     out  N_SW    debounced switch level
//  sw_change    out  N_SW    1-cycle pulse when sw_level[j] changes (either direction)
// BEHAVIOUR
//  - One clock domain; reset synchronous, active-high; everything registered, no combinational in->out path.
//  - Reset values:
//      sync flops and stable regs: keys all-1 (released), switches all-0.
//      Counters: 0.
//      key_level = all-1; sw_level = 0; key_press, key_release, sw_change = 0.
//  - Synchronizer: s1 <= raw; s2 <= s1. Only s2 is used downstream.
//  - Per-bit debounce, identical and independent for every key and switch bit:
//      s2 == stable:                              cnt <= 0
//      s2 != stable, cnt <  DEBOUNCE_CYCLES-1:    cnt <= cnt+1
//      s2 != stable, cnt == DEBOUNCE_CYCLES-1:    stable <= s2; cnt <= 0; edge pulse registered for one cycle
//  - Any single cycle of agreement (bounce) clears cnt; a change needs DEBOUNCE_CYCLES consecutive mismatching cycles.
//  - Latency: raw step held from edge t -> level output changes at edge t+2+DEBOUNCE_CYCLES.
//  - Pulse timing: the pulse is high in exactly the cycle level shows its new value.
//      Pulses are never wider than 1 cycle.
//      key_press and key_release are never high together for the same bit.
//  - Simultaneous changes on several bits: each bit is handled independently; multiple pulses may share a cycle.
//  - Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
//  - Reset mid-debounce:
//      the pending change is discarded and outputs return to reset values on the next edge;
//      a held input is re-accepted DEBOUNCE_CYCLES+2 cycles after rst falls;
//      no pulse is generated in the reset cycle.
//  - Raw inputs held at the reset value never produce pulses.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  1. Reset: rst=1 for 2 cycles, key_raw=2'b11, sw_raw=0
//     -> key_level=2'b11, sw_level=0, all pulses 0.
//  2. Clean press: key_raw[0] 1->0 at edge t, held
//     -> key_level[0]=0 and key_press[0]=1 at edge t+6 only;
//        key_press[0]=0 at t+7.
//  3. Bounce: key_raw[1] toggles 0,1,0,1 every 2 cycles, then held 0
//     -> no output change during bouncing;
//        key_press[1] exactly once, 6 cycles after the final hold begins.
//  4. Release and switch together: key_raw[0] 0->1 and sw_raw=10'h200 in the same cycle
//     -> key_release[0] and sw_change[9] high in the same cycle;
//        sw_level=10'h200;
//        no key_press pulse.
//  5. Reset mid-debounce: sw_raw[3] 0->1, assert rst 3 cycles later for 1 cycle, keep sw_raw[3]=1
//     -> sw_level[3]=0 through reset;
//        sw_level[3]=1 with sw_change[3]=1 exactly 6 cycles after rst falls.
//  6. Glitch: 1-cycle pulse on sw_raw[5]
//     -> sw_level[5] and sw_change[5] remain 0 throughout.

Source files
------------

// File: rtl/input_conditioner.sv
// Input conditioner for raw board pushbuttons and slide switches.
//
// Every key and switch bit goes through a 2-FF synchronizer and then an independent
// counter-based debouncer. The debounced level and single-cycle edge pulses are all
// registered, so no input reaches an output without passing through a flop.
//
// Ports:
//   clk_i           system clock, all logic on posedge
//   rst_i           synchronous active-high reset
//   key_raw_i       raw pushbuttons, asynchronous, 0 = pressed
//   sw_raw_i        raw slide switches, asynchronous
//   key_level_o     debounced key level, 0 = pressed
//   key_press_o     1-cycle pulse when a key level goes 1->0
//   key_release_o   1-cycle pulse when a key level goes 0->1
//   sw_level_o      debounced switch level
//   sw_change_o     1-cycle pulse when a switch level changes
module input_conditioner #(
   parameter int unsigned N_KEYS          = 2,
   parameter int unsigned N_SW            = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_KEYS-1:0] key_raw_i,
   input  logic [N_SW-1:0]   sw_raw_i,
   output logic [N_KEYS-1:0] key_level_o,
   output logic [N_KEYS-1:0] key_press_o,
   output logic [N_KEYS-1:0] key_release_o,
   output logic [N_SW-1:0]   sw_level_o,
   output logic [N_SW-1:0]   sw_change_o
);

   localparam int unsigned W     = N_KEYS + N_SW;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Keys occupy the low bits and idle high (released); switches idle low.
   localparam logic [W-1:0] RstVal = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

   logic [W-1:0]     raw;
   logic [W-1:0]     s1_q, s2_q;
   logic [W-1:0]     stable_q, stable_d;
   logic [W-1:0]     rise_q, rise_d;
   logic [W-1:0]     fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q [W];
   logic [CNT_W-1:0] cnt_d [W];

   assign raw = {sw_raw_i, key_raw_i};

   // Any cycle where the synchronized input agrees with the accepted level clears the
   // counter, so only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      for (int unsigned i = 0; i < W; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = s2_q[i];
               rise_d[i]   = s2_q[i];
               fall_d[i]   = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q     <= RstVal;
         s2_q     <= RstVal;
         stable_q <= RstVal;
         rise_q   <= '0;
         fall_q   <= '0;
         for (int unsigned i = 0; i < W; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         for (int unsigned i = 0; i < W; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Pulses update on the same edge as the level, so they line up with the new value.
   assign key_level_o   = stable_q[N_KEYS-1:0];
   assign key_press_o   = fall_q[N_KEYS-1:0];
   assign key_release_o = rise_q[N_KEYS-1:0];
   assign sw_level_o    = stable_q[W-1:N_KEYS];
   assign sw_change_o   = rise_q[W-1:N_KEYS] | fall_q[W-1:N_KEYS];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same point.
module tb_input_conditioner;

   logic       clk;
   logic       rst;
   logic [1:0] key_raw;
   logic [9:0] sw_raw;
   logic [1:0] key_level, key_press, key_release;
   logic [9:0] sw_level, sw_change;

   int checks = 0;
   int errors = 0;

   input_conditioner #(
      .N_KEYS          (2),
      .N_SW            (10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .key_raw_i     (key_raw),
      .sw_raw_i      (sw_raw),
      .key_level_o   (key_level),
      .key_press_o   (key_press),
      .key_release_o (key_release),
      .sw_level_o    (sw_level),
      .sw_change_o   (sw_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [1:0] kl, input logic [1:0] kp,
                            input logic [1:0] kr, input logic [9:0] sl, input logic [9:0] sc);
      check({tag, ".key_level"}, 32'(key_level), 32'(kl));
      check({tag, ".key_press"}, 32'(key_press), 32'(kp));
      check({tag, ".key_release"}, 32'(key_release), 32'(kr));
      check({tag, ".sw_level"}, 32'(sw_level), 32'(sl));
      check({tag, ".sw_change"}, 32'(sw_change), 32'(sc));
   endtask

   initial begin
      // 1. Reset
      rst     = 1'b1;
      key_raw = 2'b11;
      sw_raw  = 10'h000;
      tick(2);
      check_all("reset", 2'b11, 2'b00, 2'b00, 10'h000, 10'h000);
      rst = 1'b0;
      tick(1);
      check_all("post_reset", 2'b11, 2'b00, 2'b00, 10'h000, 10'h000);

      // 2. Clean press on key 0: accepted on the 6th edge after the change
      key_raw = 2'b10;
      tick(5);
      check_all("press_t5", 2'b11, 2'b00, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("press_t6", 2'b10, 2'b01, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("press_t7", 2'b10, 2'b00, 2'b00, 10'h000, 10'h000);

      // 3. Bounce on key 1: 2-cycle runs never reach the count
      for (int b = 0; b < 4; b++) begin
         key_raw[1] = b[0];
         for (int k = 0; k < 2; k++) begin
            tick(1);
            check("bounce.key_level", 32'(key_level), 32'(2'b10));
            check("bounce.key_press", 32'(key_press), 32'(2'b00));
         end
      end
      key_raw[1] = 1'b0;
      tick(5);
      check_all("bounce_t5", 2'b10, 2'b00, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("bounce_t6", 2'b00, 2'b10, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("bounce_t7", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000);

      // 4. Release key 0 and raise switch 9 together
      key_raw = 2'b01;
      sw_raw  = 10'h200;
      tick(5);
      check_all("rel_sw_t5", 2'b00, 2'b00, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("rel_sw_t6", 2'b01, 2'b00, 2'b01, 10'h200, 10'h200);
      tick(1);
      check_all("rel_sw_t7", 2'b01, 2'b00, 2'b00, 10'h200, 10'h000);

      // 5. Reset mid-debounce of switch 3; everything held is re-accepted after reset
      sw_raw = 10'h208;
      tick(3);
      check_all("mid_pre_rst", 2'b01, 2'b00, 2'b00, 10'h200, 10'h000);
      rst = 1'b1;
      tick(1);
      check_all("mid_in_rst", 2'b11, 2'b00, 2'b00, 10'h000, 10'h000);
      rst = 1'b0;
      tick(5);
      check_all("mid_t5", 2'b11, 2'b00, 2'b00, 10'h000, 10'h000);
      tick(1);
      check_all("mid_t6", 2'b01, 2'b10, 2'b00, 10'h208, 10'h208);
      tick(1);
      check_all("mid_t7", 2'b01, 2'b00, 2'b00, 10'h208, 10'h000);

      // 6. One-cycle glitch on switch 5 is ignored
      sw_raw = 10'h228;
      tick(1);
      sw_raw = 10'h208;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("glitch.sw_level", 32'(sw_level), 32'(10'h208));
         check("glitch.sw_change", 32'(sw_change), 32'(10'h000));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
